// File: rtl/vend_pkg.sv
// vend_pkg: types and constants shared by the vending front-end blocks.
//   coin_type_e  : encoding of the coin_type input (two bits).
//   COIN_VAL_*   : cent value of each coin type.
//   credit_st_e  : state encoding of vend_credit_accumulator.
package vend_pkg;

   typedef enum logic [1:0] {
      COIN_5   = 2'd0,
      COIN_10  = 2'd1,
      COIN_25  = 2'd2,
      COIN_100 = 2'd3
   } coin_type_e;

   localparam int unsigned COIN_VAL_5   = 5;
   localparam int unsigned COIN_VAL_10  = 10;
   localparam int unsigned COIN_VAL_25  = 25;
   localparam int unsigned COIN_VAL_100 = 100;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COLLECT = 3'd1,
      ST_READY   = 3'd2,
      ST_VEND    = 3'd3,
      ST_REFUND  = 3'd4
   } credit_st_e;

endpackage

// File: rtl/vend_coin_decode.sv
// vend_coin_decode: combinational coin_type -> cent value lookup.
//   coin_type  in  2         coin encoding (see vend_pkg::coin_type_e)
//   coin_value out CREDIT_W  value in cents, zero-extended
module vend_coin_decode
   import vend_pkg::*;
#(
   parameter int CREDIT_W = 16
) (
   input  logic [1:0]          coin_type,
   output logic [CREDIT_W-1:0] coin_value
);

   always_comb begin
      coin_value = '0;
      unique case (coin_type_e'(coin_type))
         COIN_5:   coin_value = CREDIT_W'(COIN_VAL_5);
         COIN_10:  coin_value = CREDIT_W'(COIN_VAL_10);
         COIN_25:  coin_value = CREDIT_W'(COIN_VAL_25);
         COIN_100: coin_value = CREDIT_W'(COIN_VAL_100);
         default:  coin_value = '0;
      endcase
   end

endmodule

// File: rtl/vend_credit_accumulator.sv
// vend_credit_accumulator: collects coins/bills, tracks credit, drives the
// vending FSM's condition/sel inputs, deducts the price on vend_ack and
// returns change over a valid/ready handshake. All outputs are registered.
//
//   clk            in   system clock
//   reset_n        in   synchronous active-low reset
//   coin_valid     in   one-cycle insertion strobe
//   coin_type      in   0=5c 1=10c 2=25c 3=100c bill
//   cancel         in   one-cycle refund request
//   vend_ack       in   one-cycle "item sold" strobe
//   change_ready   in   change dispenser accepts
//   condition      out  credit covers price (state READY)
//   sel            out  a bill was accepted in this transaction
//   credit         out  current credit in cents
//   coin_reject    out  one-cycle pulse: last insertion refused
//   change_valid   out  change offer pending
//   change_amount  out  change in cents, stable while change_valid
//
// state      | meaning
// -----------+-------------------------------------------------
// ST_IDLE    | no credit, waiting for first coin
// ST_COLLECT | 0 < credit < PRICE, accepting coins
// ST_READY   | credit >= PRICE, condition high, awaiting vend_ack
// ST_VEND    | single cycle: price deducted from credit
// ST_REFUND  | change offered, waiting for change_ready
module vend_credit_accumulator
   import vend_pkg::*;
#(
   parameter int CREDIT_W   = 16,
   parameter int PRICE      = 150,
   parameter int MAX_CREDIT = 1000
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                coin_valid,
   input  logic [1:0]          coin_type,
   input  logic                cancel,
   input  logic                vend_ack,
   input  logic                change_ready,
   output logic                condition,
   output logic                sel,
   output logic [CREDIT_W-1:0] credit,
   output logic                coin_reject,
   output logic                change_valid,
   output logic [CREDIT_W-1:0] change_amount
);

   localparam logic [CREDIT_W-1:0] PRICE_W  = CREDIT_W'(PRICE);
   localparam logic [CREDIT_W:0]   MAX_EXT  = (CREDIT_W+1)'(MAX_CREDIT);

   credit_st_e          state;
   logic [CREDIT_W-1:0] coin_value;
   logic [CREDIT_W:0]   sum_ext;
   logic [CREDIT_W-1:0] sum;
   logic [CREDIT_W-1:0] remainder;
   logic                is_bill;
   logic                coin_fits;
   logic                accepting;
   logic                coin_ok;

   vend_coin_decode #(.CREDIT_W(CREDIT_W)) u_coin_decode (
      .coin_type  (coin_type),
      .coin_value (coin_value)
   );

   // One extra bit on the sum so the ceiling check cannot wrap.
   assign sum_ext   = {1'b0, credit} + {1'b0, coin_value};
   assign sum       = sum_ext[CREDIT_W-1:0];
   assign coin_fits = (sum_ext <= MAX_EXT);
   assign remainder = credit - PRICE_W;
   assign is_bill   = (coin_type_e'(coin_type) == COIN_100);

   assign accepting = (state == ST_IDLE) || (state == ST_COLLECT) || (state == ST_READY);
   // cancel/vend_ack take priority over a coin in the same cycle, so the coin
   // is refused even where the strobe itself ends up being ignored.
   assign coin_ok   = coin_valid && accepting && !cancel && !vend_ack && coin_fits;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state         <= ST_IDLE;
         credit        <= '0;
         condition     <= 1'b0;
         sel           <= 1'b0;
         coin_reject   <= 1'b0;
         change_valid  <= 1'b0;
         change_amount <= '0;
      end else begin
         coin_reject <= coin_valid && !coin_ok;

         unique case (state)
            ST_IDLE: begin
               if (coin_ok) begin
                  credit <= sum;
                  if (is_bill) sel <= 1'b1;
                  if (sum >= PRICE_W) begin
                     state     <= ST_READY;
                     condition <= 1'b1;
                  end else begin
                     state     <= ST_COLLECT;
                  end
               end
            end

            ST_COLLECT, ST_READY: begin
               if (cancel) begin
                  state         <= ST_REFUND;
                  condition     <= 1'b0;
                  change_valid  <= 1'b1;
                  change_amount <= credit;
               end else if (vend_ack && (state == ST_READY)) begin
                  state     <= ST_VEND;
                  condition <= 1'b0;
               end else if (coin_ok) begin
                  credit <= sum;
                  if (is_bill) sel <= 1'b1;
                  if (sum >= PRICE_W) begin
                     state     <= ST_READY;
                     condition <= 1'b1;
                  end
               end
            end

            ST_VEND: begin
               // Only reachable from READY, so credit >= PRICE here.
               credit <= remainder;
               if (remainder != '0) begin
                  state         <= ST_REFUND;
                  change_valid  <= 1'b1;
                  change_amount <= remainder;
               end else begin
                  state <= ST_IDLE;
                  sel   <= 1'b0;
               end
            end

            ST_REFUND: begin
               if (change_ready) begin
                  state         <= ST_IDLE;
                  credit        <= '0;
                  sel           <= 1'b0;
                  change_valid  <= 1'b0;
                  change_amount <= '0;
               end
            end

            default: begin
               state         <= ST_IDLE;
               credit        <= '0;
               condition     <= 1'b0;
               sel           <= 1'b0;
               change_valid  <= 1'b0;
               change_amount <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vend_credit_accumulator.sv
module tb_vend_credit_accumulator;

   localparam int CREDIT_W   = 16;
   localparam int PRICE      = 150;
   localparam int MAX_CREDIT = 1000;

   logic                clk = 1'b0;
   logic                reset_n;
   logic                coin_valid;
   logic [1:0]          coin_type;
   logic                cancel;
   logic                vend_ack;
   logic                change_ready;
   logic                condition;
   logic                sel;
   logic [CREDIT_W-1:0] credit;
   logic                coin_reject;
   logic                change_valid;
   logic [CREDIT_W-1:0] change_amount;

   vend_credit_accumulator #(
      .CREDIT_W(CREDIT_W), .PRICE(PRICE), .MAX_CREDIT(MAX_CREDIT)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .coin_valid    (coin_valid),
      .coin_type     (coin_type),
      .cancel        (cancel),
      .vend_ack      (vend_ack),
      .change_ready  (change_ready),
      .condition     (condition),
      .sel           (sel),
      .credit        (credit),
      .coin_reject   (coin_reject),
      .change_valid  (change_valid),
      .change_amount (change_amount)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: credit as a plain integer plus a transaction mode.
   // condition is simply "normal mode and credit covers the price".
   localparam int MODE_NORMAL = 0;
   localparam int MODE_VEND   = 1;
   localparam int MODE_REFUND = 2;
   int coin_cents [4] = '{5, 10, 25, 100};
   int m_credit, m_sel, m_mode, m_amt, m_rej;

   task automatic model_reset();
      m_credit = 0; m_sel = 0; m_mode = MODE_NORMAL; m_amt = 0; m_rej = 0;
   endtask

   task automatic model_step(input bit cv, input bit [1:0] ct, input bit cn,
                             input bit va, input bit cr);
      bit accepted = 0;
      if (m_mode == MODE_REFUND) begin
         if (cr) begin
            m_credit = 0; m_sel = 0; m_amt = 0; m_mode = MODE_NORMAL;
         end
      end else if (m_mode == MODE_VEND) begin
         m_credit = m_credit - PRICE;
         if (m_credit > 0) begin
            m_mode = MODE_REFUND; m_amt = m_credit;
         end else begin
            m_mode = MODE_NORMAL; m_sel = 0;
         end
      end else begin
         if (cn && m_credit > 0) begin
            m_mode = MODE_REFUND; m_amt = m_credit;
         end else if (va && m_credit >= PRICE) begin
            m_mode = MODE_VEND;
         end else if (cv && !cn && !va && (m_credit + coin_cents[ct] <= MAX_CREDIT)) begin
            accepted = 1;
            m_credit = m_credit + coin_cents[ct];
            if (ct == 2'd3) m_sel = 1;
         end
      end
      m_rej = (cv && !accepted) ? 1 : 0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      bit cond_exp = (m_mode == MODE_NORMAL) && (m_credit >= PRICE);
      chk({tag, ".credit"},        32'(credit),        32'(m_credit));
      chk({tag, ".condition"},     32'(condition),     32'(cond_exp));
      chk({tag, ".sel"},           32'(sel),           32'(m_sel));
      chk({tag, ".coin_reject"},   32'(coin_reject),   32'(m_rej));
      chk({tag, ".change_valid"},  32'(change_valid),  32'(m_mode == MODE_REFUND));
      chk({tag, ".change_amount"}, 32'(change_amount), 32'(m_amt));
   endtask

   // Drive inputs, let the DUT take one edge, advance the model, compare #1 later.
   task automatic step(input string tag, input bit cv, input bit [1:0] ct,
                       input bit cn, input bit va, input bit cr);
      coin_valid = cv; coin_type = ct; cancel = cn; vend_ack = va; change_ready = cr;
      @(posedge clk);
      model_step(cv, ct, cn, va, cr);
      #1;
      check_all(tag);
   endtask

   task automatic do_reset(input string tag);
      reset_n = 1'b0;
      coin_valid = 0; coin_type = 0; cancel = 0; vend_ack = 0; change_ready = 0;
      @(posedge clk);
      model_reset();
      #1;
      check_all(tag);
      reset_n = 1'b1;
   endtask

   task automatic coin(input string tag, input bit [1:0] ct);
      step(tag, 1, ct, 0, 0, 0);
   endtask

   initial begin
      reset_n = 1'b0;
      coin_valid = 0; coin_type = 0; cancel = 0; vend_ack = 0; change_ready = 0;
      model_reset();
      @(posedge clk);
      do_reset("reset");

      // 1: 100 + 25 + 25 reaches the price
      coin("s1_c100", 2'd3); chk("s1_credit100", 32'(credit), 100);
      coin("s1_c25a", 2'd2); chk("s1_credit125", 32'(credit), 125);
      coin("s1_c25b", 2'd2); chk("s1_credit150", 32'(credit), 150);
      chk("s1_condition", 32'(condition), 1);
      chk("s1_sel", 32'(sel), 1);

      // 2: exact payment, no change
      step("s2_ack", 0, 0, 0, 1, 1);
      chk("s2_cond_low", 32'(condition), 0);
      step("s2_vend", 0, 0, 0, 0, 1);
      chk("s2_no_change", 32'(change_valid), 0);
      chk("s2_credit0", 32'(credit), 0);

      // 3: 250 credit, change 100 held while dispenser is busy
      coin("s3_c100a", 2'd3); coin("s3_c25a", 2'd2); coin("s3_c25b", 2'd2);
      coin("s3_c100b", 2'd3);
      chk("s3_credit250", 32'(credit), 250);
      step("s3_ack", 0, 0, 0, 1, 0);
      step("s3_vend", 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) step("s3_hold", 0, 0, 0, 0, 0);
         chk("s3_valid", 32'(change_valid), 1);
         chk("s3_amount", 32'(change_amount), 100);
      end
      step("s3_accept", 0, 0, 0, 0, 1);
      chk("s3_cleared", 32'(change_valid), 0);

      // 4: credit ceiling
      for (int i = 0; i < 9; i++) coin("s4_bill", 2'd3);
      coin("s4_c25a", 2'd2); coin("s4_c25b", 2'd2);
      chk("s4_credit950", 32'(credit), 950);
      coin("s4_over", 2'd3);
      chk("s4_reject", 32'(coin_reject), 1);
      chk("s4_credit_kept", 32'(credit), 950);
      coin("s4_c25c", 2'd2);
      chk("s4_reject_clr", 32'(coin_reject), 0);
      chk("s4_credit975", 32'(credit), 975);
      step("s4_cancel", 0, 0, 1, 0, 0);
      step("s4_accept", 0, 0, 0, 0, 1);

      // 5: cancel beats a simultaneous coin
      coin("s5_c25", 2'd2); coin("s5_c10", 2'd1);
      step("s5_cancel_coin", 1, 2'd1, 1, 0, 0);
      chk("s5_reject", 32'(coin_reject), 1);
      chk("s5_amount", 32'(change_amount), 35);
      chk("s5_sel", 32'(sel), 0);
      step("s5_accept", 0, 0, 0, 0, 1);

      // 6: reset drops a pending refund
      coin("s6_c25a", 2'd2); coin("s6_c25b", 2'd2); coin("s6_c10", 2'd1);
      step("s6_cancel", 0, 0, 1, 0, 0);
      chk("s6_amount60", 32'(change_amount), 60);
      do_reset("s6_reset");
      chk("s6_valid_low", 32'(change_valid), 0);

      // Randomized traffic against the model
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset("rnd_reset");
         end else begin
            step("rnd",
                 ($urandom_range(0, 99) < 55),
                 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 99) < 4),
                 ($urandom_range(0, 99) < 12),
                 ($urandom_range(0, 99) < 40));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
